apb_slave_ws: RTL and testbench
===============================

Name: apb_slave_ws

Overview:
- Parametrised APB slave front-end for timer-class peripherals; successor to the fixed 8-register, zero-wait, always-ready decoder.
- Adds programmable wait states, generic register-count decode, per-register read-only protection, latched setup-phase decode and protocol-abort handling.
- Adds a saturating error counter.
- Sits between the APB interconnect and the peripheral register file. Drives single-cycle write/read strobes plus a register index; returns read data to APB.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, data width (multiple of 8).
- NUM_REGS, 8, number of word registers at byte offsets 0, 4, … 4*(NUM_REGS-1); 1..64.
- WAIT_CYCLES, 0, pready-low cycles inserted in each access phase; 0..15.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 means register i is read-only, and a write to it is an error.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- tim_psel  in  1  APB select.
- tim_penable  in  1  APB enable.
- tim_pwrite  in  1  1=write, 0=read.
- tim_paddr  in  ADDR_W  byte address.
- tim_pwdata  in  DATA_W  write data.
- tim_pstrb  in  DATA_W/8  byte strobes; present only with APB_STRB_EN.
- tim_prdata  out  DATA_W  read data.
- tim_pready  out  1  transfer complete.
- tim_pslverr  out  1  error response, valid with pready.
- wr_en  out  1  one-cycle register write strobe.
- rd_en  out  1  one-cycle register read strobe.
- reg_idx  out  clog2(NUM_REGS) (min 1)  latched register index.
- wr_data  out  DATA_W  latched write data.
- wr_strb  out  DATA_W/8  latched byte enables.
- rd_data  in  DATA_W  register-file read data for reg_idx, combinational.
- err_clr  in  1  clear error counter.
- err_cnt  out  8  saturating error-response count.

Behaviour:
- **Reset:** state IDLE, wait counter 0, reg_idx 0, wr_data 0, wr_strb 0, err_cnt 0. Reset also forces pready, pslverr, wr_en, rd_en and prdata to 0.
- **FSM states:** IDLE and ACCESS.
- **IDLE:**
  - psel=1 and penable=0 (setup phase): latch write flag, reg_idx=paddr[..:2], wr_data, wr_strb and the valid flag; load wait counter with WAIT_CYCLES; go to ACCESS.
  - psel=1 and penable=1 with no prior setup is a protocol error: pready=1 and pslverr=1 combinationally that cycle, no strobes, err_cnt increments, stay in IDLE.
- **Valid access:** paddr[1:0]==0, word index < NUM_REGS, and all upper address bits beyond the index decode are 0. A write additionally requires RO_MASK[idx]==0.
- **ACCESS with psel=1 and penable=1:**
  - Counter != 0: decrement; pready=0.
  - Counter == 0: pready=1, the completion cycle.
  - Next state after completion is IDLE. A setup phase in the cycle after completion is accepted, so back-to-back transfers run with no idle gap.
- **ACCESS with psel=0 (abort):** return to IDLE; no pready, no strobes, err_cnt unchanged.
- **Completion cycle outputs:**
  - Valid write: wr_en=1.
  - Valid read: rd_en=1 and prdata=rd_data.
  - Invalid access: pslverr=1, no strobe, prdata=0.
  - pslverr is 0 whenever pready=0. prdata is 0 outside read completions.
- **Latency:** every transfer completes in exactly 1+WAIT_CYCLES access-phase cycles. Address and data changes after setup are ignored.
- **err_cnt:** +1 per pslverr completion; saturates at 255. err_clr alone sets it to 0. err_clr together with an error in the same cycle sets it to 1.
- **Mid-transfer reset:** returns to IDLE immediately; no strobe is emitted.

Optional Feature:
- Macro: APB_STRB_EN.
- Defined:
  - The tim_pstrb port exists and is latched into wr_strb at setup.
  - A read with nonzero tim_pstrb completes with pslverr=1, per APB4.
  - A write with pstrb=0 completes normally with wr_en=1 and wr_strb=0.
- Undefined: the tim_pstrb port is absent and wr_strb latches all ones on every write setup.

Test Plan:
- WAIT_CYCLES=0, write 0xA5A5_0001 to 0x08 → pready and wr_en high in the first access cycle; reg_idx=2, wr_data=0xA5A5_0001, pslverr=0.
- WAIT_CYCLES=3, read 0x0C with rd_data=0x1234 → pready low for 3 access cycles, then pready=1, rd_en=1, prdata=0x1234 on the 4th.
- Read 0x20 (NUM_REGS=8), then 0x06 (misaligned) → each completes with pslverr=1, no strobes, prdata=0; err_cnt=2.
- RO_MASK=0x40, write to 0x18 → pslverr=1, wr_en=0. A read of 0x18 succeeds.
- WAIT_CYCLES=2, drop psel after one access cycle, then a new write setup to 0x00 → first transfer gives no pready and no strobe; second completes 3 cycles later with wr_en=1, reg_idx=0.
- err_cnt preloaded to 255 via 255 errors, one more error → stays 255. Assert err_clr concurrent with an error → err_cnt=1.

Source files
------------

// File: rtl/apb_slave_ws.sv
// APB slave front-end with programmable wait states for timer-class peripherals.
// Decodes NUM_REGS word registers. A write to a register flagged in RO_MASK is an error.
// The setup-phase decode is latched. A transfer whose psel drops mid-access is abandoned.
// A saturating 8-bit counter records error responses.
// Optional feature macro APB_STRB_EN adds the tim_pstrb port.
// Without the macro, writes latch all-ones byte enables.
module apb_slave_ws #(
  parameter int unsigned          ADDR_W      = 12,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  localparam int unsigned         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned         STRB_W      = DATA_W / 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                tim_psel,
  input  logic                tim_penable,
  input  logic                tim_pwrite,
  input  logic [ADDR_W-1:0]   tim_paddr,
  input  logic [DATA_W-1:0]   tim_pwdata,
`ifdef APB_STRB_EN
  input  logic [STRB_W-1:0]   tim_pstrb,
`endif
  output logic [DATA_W-1:0]   tim_prdata,
  output logic                tim_pready,
  output logic                tim_pslverr,
  output logic                wr_en,
  output logic                rd_en,
  output logic [IDX_W-1:0]    reg_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [STRB_W-1:0]   wr_strb,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                err_clr,
  output logic [7:0]          err_cnt
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e              state_q;
  logic [3:0]          wait_q;
  logic                write_q;
  logic                valid_q;
  logic [IDX_W-1:0]    reg_idx_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [STRB_W-1:0]   wr_strb_q;
  logic [7:0]          err_cnt_q, err_cnt_d;

  // Setup-phase address decode
  logic [IDX_W-1:0]    addr_idx;
  logic [ADDR_W-1:0]   addr_hi;
  logic [NUM_REGS-1:0] ro_sh;
  logic                addr_ok;
  logic                setup_valid;

  assign addr_idx = tim_paddr[IDX_W+1:2];
  assign addr_hi  = tim_paddr >> (IDX_W + 2);
  // Shift rather than index so an out-of-range idx never selects past the mask
  assign ro_sh    = RO_MASK >> addr_idx;
  assign addr_ok  = (tim_paddr[1:0] == 2'b00) && (addr_hi == '0) &&
                    ({{(32 - IDX_W){1'b0}}, addr_idx} < NUM_REGS);

`ifdef APB_STRB_EN
  // APB4: reads must not carry byte strobes
  assign setup_valid = addr_ok && (tim_pwrite ? !ro_sh[0] : (tim_pstrb == '0));
`else
  assign setup_valid = addr_ok && (!tim_pwrite || !ro_sh[0]);
`endif

  // FSM: latch setup decode, count wait states, return to idle on completion or abort
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      write_q   <= 1'b0;
      valid_q   <= 1'b0;
      reg_idx_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        StIdle: begin
          if (tim_psel && !tim_penable) begin
            write_q   <= tim_pwrite;
            valid_q   <= setup_valid;
            reg_idx_q <= addr_idx;
            wr_data_q <= tim_pwdata;
`ifdef APB_STRB_EN
            wr_strb_q <= tim_pstrb;
`else
            if (tim_pwrite) wr_strb_q <= '1;
`endif
            wait_q    <= 4'(WAIT_CYCLES);
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          if (!tim_psel) begin
            state_q <= StIdle;
          end else if (tim_penable) begin
            if (wait_q != 4'd0) wait_q  <= wait_q - 4'd1;
            else                state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Completion and protocol-error responses; all forced low while in reset
  always_comb begin
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    tim_prdata  = '0;
    if (sys_rst_n && tim_psel && tim_penable) begin
      if (state_q == StIdle) begin
        // Enable without a preceding setup phase
        tim_pready  = 1'b1;
        tim_pslverr = 1'b1;
      end else if (wait_q == 4'd0) begin
        tim_pready = 1'b1;
        if (!valid_q) begin
          tim_pslverr = 1'b1;
        end else if (write_q) begin
          wr_en = 1'b1;
        end else begin
          rd_en      = 1'b1;
          tim_prdata = rd_data;
        end
      end
    end
  end

  // Saturating error counter; clear wins over history but not over a same-cycle error
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = tim_pslverr ? 8'd1 : 8'd0;
    end else if (tim_pslverr && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign reg_idx = reg_idx_q;
  assign wr_data = wr_data_q;
  assign wr_strb = wr_strb_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_ws.sv
// Self-checking bench for apb_slave_ws: three instances with different wait-state / RO configs.
module tb_apb_slave_ws;

  typedef struct {
    logic        err;
    logic        wr;
    logic        rd;
    logic [31:0] rdata;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic        is_write;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [11:0] paddr   [3];
  logic [31:0] pwdata  [3];
`ifdef APB_STRB_EN
  logic [3:0]  pstrb   [3];
`endif
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic        wr_en   [3];
  logic        rd_en   [3];
  logic [2:0]  reg_idx [3];
  logic [31:0] wr_data [3];
  logic [3:0]  wr_strb [3];
  logic [31:0] rd_data [3];
  logic        err_clr [3];
  logic [7:0]  err_cnt [3];

  int         waits   [3] = '{0, 3, 2};
  logic [7:0] ro      [3] = '{8'h40, 8'h00, 8'h00};
  int         exp_err [3];
  exp_t       sb[$];
  int         n_checks;
  int         n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_slave_ws #(.WAIT_CYCLES(0), .RO_MASK(8'h40)) u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tim_psel(psel[0]), .tim_penable(penable[0]),
    .tim_pwrite(pwrite[0]), .tim_paddr(paddr[0]), .tim_pwdata(pwdata[0]),
`ifdef APB_STRB_EN
    .tim_pstrb(pstrb[0]),
`endif
    .tim_prdata(prdata[0]), .tim_pready(pready[0]), .tim_pslverr(pslverr[0]),
    .wr_en(wr_en[0]), .rd_en(rd_en[0]), .reg_idx(reg_idx[0]), .wr_data(wr_data[0]),
    .wr_strb(wr_strb[0]), .rd_data(rd_data[0]), .err_clr(err_clr[0]), .err_cnt(err_cnt[0])
  );

  apb_slave_ws #(.WAIT_CYCLES(3)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tim_psel(psel[1]), .tim_penable(penable[1]),
    .tim_pwrite(pwrite[1]), .tim_paddr(paddr[1]), .tim_pwdata(pwdata[1]),
`ifdef APB_STRB_EN
    .tim_pstrb(pstrb[1]),
`endif
    .tim_prdata(prdata[1]), .tim_pready(pready[1]), .tim_pslverr(pslverr[1]),
    .wr_en(wr_en[1]), .rd_en(rd_en[1]), .reg_idx(reg_idx[1]), .wr_data(wr_data[1]),
    .wr_strb(wr_strb[1]), .rd_data(rd_data[1]), .err_clr(err_clr[1]), .err_cnt(err_cnt[1])
  );

  apb_slave_ws #(.WAIT_CYCLES(2)) u_dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tim_psel(psel[2]), .tim_penable(penable[2]),
    .tim_pwrite(pwrite[2]), .tim_paddr(paddr[2]), .tim_pwdata(pwdata[2]),
`ifdef APB_STRB_EN
    .tim_pstrb(pstrb[2]),
`endif
    .tim_prdata(prdata[2]), .tim_pready(pready[2]), .tim_pslverr(pslverr[2]),
    .wr_en(wr_en[2]), .rd_en(rd_en[2]), .reg_idx(reg_idx[2]), .wr_data(wr_data[2]),
    .wr_strb(wr_strb[2]), .rd_data(rd_data[2]), .err_clr(err_clr[2]), .err_cnt(err_cnt[2])
  );

  // One APB transfer on instance d; expectation pushed at setup, popped at pready.
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                          input logic [31:0] data, input logic [31:0] rdv);
    exp_t       e;
    exp_t       got;
    int         cyc;
    bit         done;
    logic [9:0] wi;
    wi         = addr[11:2];
    e.err      = (addr[1:0] != 2'b00) || (wi >= 10'd8) || (wr && ro[d][wi[2:0]]);
    e.wr       = wr && !e.err;
    e.rd       = !wr && !e.err;
    e.rdata    = e.rd ? rdv : 32'h0;
    e.idx      = wi[2:0];
    e.wdata    = data;
    e.is_write = wr;
    e.lat      = 1 + waits[d];
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
`ifdef APB_STRB_EN
    pstrb[d] = wr ? 4'hF : 4'h0;
`endif
    rd_data[d] = rdv;
    @(posedge clk); #1;
    // Address/data are scrambled after setup; the DUT must use the latched values
    penable[d] = 1'b1; paddr[d] = 12'($urandom); pwdata[d] = $urandom;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (err_cnt[d] !== 8'(exp_err[d])) begin
          n_errors++;
          $display("FAIL err_cnt_pre d%0d: got %0d expected %0d", d, err_cnt[d], exp_err[d]);
        end
      end
      if (pready[d] === 1'b1) begin
        done = 1'b1;
        got  = sb.pop_front();
        n_checks++;
        if (cyc != got.lat) begin
          n_errors++;
          $display("FAIL latency d%0d addr %h: got %0d expected %0d", d, addr, cyc, got.lat);
        end
        n_checks++;
        if ({pslverr[d], wr_en[d], rd_en[d]} !== {got.err, got.wr, got.rd}) begin
          n_errors++;
          $display("FAIL resp d%0d addr %h: got slverr/wr/rd %b%b%b expected %b%b%b", d, addr,
                   pslverr[d], wr_en[d], rd_en[d], got.err, got.wr, got.rd);
        end
        n_checks++;
        if (prdata[d] !== got.rdata) begin
          n_errors++;
          $display("FAIL prdata d%0d addr %h: got %h expected %h", d, addr, prdata[d], got.rdata);
        end
        n_checks++;
        if (reg_idx[d] !== got.idx) begin
          n_errors++;
          $display("FAIL reg_idx d%0d addr %h: got %0d expected %0d", d, addr, reg_idx[d], got.idx);
        end
        if (got.is_write) begin
          n_checks++;
          if ({wr_data[d], wr_strb[d]} !== {got.wdata, 4'hF}) begin
            n_errors++;
            $display("FAIL wr_data d%0d: got %h/%h expected %h/f", d, wr_data[d], wr_strb[d],
                     got.wdata);
          end
        end
        if (got.err && exp_err[d] < 255) exp_err[d]++;
      end else begin
        n_checks++;
        if ({pslverr[d], wr_en[d], rd_en[d], prdata[d]} !== 35'h0) begin
          n_errors++;
          $display("FAIL wait_quiet d%0d cyc %0d: got slverr/wr/rd/prdata %b%b%b/%h expected 0",
                   d, cyc, pslverr[d], wr_en[d], rd_en[d], prdata[d]);
        end
      end
      @(posedge clk); #1;
      paddr[d] = 12'($urandom); pwdata[d] = $urandom;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout d%0d addr %h: got no pready expected pready", d, addr);
      void'(sb.pop_front());
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    // Enable without setup during reset must not produce a response
    psel[0] = 1'b1; penable[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({pready[d], pslverr[d], wr_en[d], rd_en[d], prdata[d], reg_idx[d], wr_data[d],
           wr_strb[d], err_cnt[d]} !== 82'h0) begin
        n_errors++;
        $display("FAIL reset d%0d: got rdy/err/wr/rd %b%b%b%b prdata %h idx %0d wd %h ws %h cnt %0d expected all 0",
                 d, pready[d], pslverr[d], wr_en[d], rd_en[d], prdata[d], reg_idx[d], wr_data[d],
                 wr_strb[d], err_cnt[d]);
      end
      exp_err[d] = 0;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_w0();
    apb_xfer(0, 1'b1, 12'h008, 32'hA5A5_0001, 32'h0);
  endtask

  task automatic test_read_wait();
    apb_xfer(1, 1'b0, 12'h00C, 32'h0, 32'h0000_1234);
  endtask

  task automatic test_invalid();
    apb_xfer(1, 1'b0, 12'h020, 32'h0, 32'hDEAD_BEEF);
    apb_xfer(1, 1'b0, 12'h006, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    n_checks++;
    if (err_cnt[1] !== 8'd2) begin
      n_errors++;
      $display("FAIL invalid_err_cnt: got %0d expected 2", err_cnt[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_only();
    apb_xfer(0, 1'b1, 12'h018, 32'h1111_2222, 32'h0);
    apb_xfer(0, 1'b0, 12'h018, 32'h0, 32'h5555_AAAA);
  endtask

  task automatic test_protocol_err();
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({pready[0], pslverr[0], wr_en[0], rd_en[0], prdata[0]} !== {4'b1100, 32'h0}) begin
      n_errors++;
      $display("FAIL protocol_err: got rdy/err/wr/rd %b%b%b%b prdata %h expected 1100/0",
               pready[0], pslverr[0], wr_en[0], rd_en[0], prdata[0]);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    exp_err[0]++;
    apb_xfer(0, 1'b0, 12'h004, 32'h0, 32'hCAFE_0004);
  endtask

  task automatic test_back_to_back();
    apb_xfer(0, 1'b1, 12'h000, 32'h0000_0010, 32'h0);
    apb_xfer(0, 1'b1, 12'h01C, 32'h0000_0020, 32'h0);
    apb_xfer(0, 1'b0, 12'h01C, 32'h0, 32'h8765_4321);
    apb_xfer(0, 1'b1, 12'h040, 32'h0000_0030, 32'h0);
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 32'h0F0F_0F0F);
    apb_xfer(1, 1'b1, 12'h014, 32'hBEEF_0005, 32'h0);
    apb_xfer(1, 1'b0, 12'h81C, 32'h0, 32'h1357_9BDF);
    apb_xfer(1, 1'b0, 12'h004, 32'h0, 32'h2468_ACE0);
  endtask

  task automatic test_abort();
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 12'h00C;
    pwdata[2] = 32'h7777_0000;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pready[2], pslverr[2], wr_en[2], rd_en[2]} !== 4'b0000) begin
        n_errors++;
        $display("FAIL abort_quiet cyc %0d: got rdy/err/wr/rd %b%b%b%b expected 0000", i,
                 pready[2], pslverr[2], wr_en[2], rd_en[2]);
      end
      @(posedge clk); #1;
      psel[2] = 1'b0; penable[2] = 1'b0;
    end
    apb_xfer(2, 1'b1, 12'h000, 32'h0BAD_F00D, 32'h0);
  endtask

  task automatic test_mid_reset();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h008;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pready[1], pslverr[1], wr_en[1], rd_en[1]} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset: got rdy/err/wr/rd %b%b%b%b expected 0000", pready[1],
               pslverr[1], wr_en[1], rd_en[1]);
    end
    for (int d = 0; d < 3; d++) exp_err[d] = 0;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1, 1'b0, 12'h008, 32'h0, 32'h0000_ABCD);
  endtask

  task automatic test_err_sat();
    psel[2] = 1'b1; penable[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_err[2] < 255) exp_err[2]++;
    end
    @(negedge clk);
    n_checks++;
    if (err_cnt[2] !== 8'(exp_err[2])) begin
      n_errors++;
      $display("FAIL err_count: got %0d expected %0d", err_cnt[2], exp_err[2]);
    end
    for (int i = 0; i < 160; i++) begin
      @(posedge clk); #1;
      if (exp_err[2] < 255) exp_err[2]++;
    end
    @(negedge clk);
    n_checks++;
    if (err_cnt[2] !== 8'd255) begin
      n_errors++;
      $display("FAIL err_saturate: got %0d expected 255", err_cnt[2]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (err_cnt[2] !== 8'd255) begin
      n_errors++;
      $display("FAIL err_hold_255: got %0d expected 255", err_cnt[2]);
    end
    err_clr[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (err_cnt[2] !== 8'd1) begin
      n_errors++;
      $display("FAIL err_clr_with_err: got %0d expected 1", err_cnt[2]);
    end
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1;
    err_clr[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt[2] !== 8'd0) begin
      n_errors++;
      $display("FAIL err_clr_alone: got %0d expected 0", err_cnt[2]);
    end
    @(posedge clk); #1;
    exp_err[2] = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      rd_data[d] = '0; err_clr[d] = 1'b0; exp_err[d] = 0;
`ifdef APB_STRB_EN
      pstrb[d] = '0;
`endif
    end
    test_reset();
    test_write_w0();
    test_read_wait();
    test_invalid();
    test_read_only();
    test_protocol_err();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_err_sat();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
